game_sequencer: RTL and testbench
=================================

# game_sequencer

Top-level game controller that sequences the per-frame gameplay around the player and dragon entity blocks. It runs the game state machine (title, play, hurt, win, lose) and generates the divided move ticks that pace player and dragon updates. It detects player/dragon and sword/dragon tile collisions from the entities' locations, and owns player health and dragon segment count. It sits between the controller input and the entity modules, one update per frame_clk.

## Interface
- PLAYER_TICK_DIV, 4: frames per player move tick (≥2)
- DRAGON_TICK_DIV, 8: frames per dragon move tick (≥2)
- HURT_FRAMES, 30: invulnerability length in frames after a player hit
- MAX_HEALTH, 3: starting player hearts (≤3)
- DRAGON_LEN, 6: starting dragon segments (≤15)

- frame_clk  in  1  frame clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  controller START button, level
- player_loc  in  8  player tile {X[7:4], Y[3:0]}
- dragon_loc  in  8  dragon head tile {X[7:4], Y[3:0]}
- sword_loc  in  8  sword tile {X[7:4], Y[3:0]}
- sword_active  in  1  sword currently deployed
- game_state  out  3  current state encoding
- entity_rst  out  1  hold entity modules in reset
- player_tick  out  1  one-frame enable for player update
- dragon_tick  out  1  one-frame enable for dragon update
- player_health  out  2  remaining hearts
- dragon_segments  out  4  remaining dragon segments
- invuln  out  1  player invulnerable (HURT state)

## Operation
- States: TITLE=0, PLAY=1, HURT=2, WIN=3, LOSE=4; codes 5–7 → TITLE next frame.
- start_rise = start & ~start_q, where start_q is registered start.
- TITLE: entity_rst=1, ticks 0. On start_rise: load health=MAX_HEALTH, segments=DRAGON_LEN, clear tick counters, → PLAY.
- PLAY/HURT: tick counters run. Counter counts 0..DIV-1; tick=1 during the frame the counter equals DIV-1, then wraps to 0.
- p_hit = (player_loc == dragon_loc). s_hit = sword_active & (sword_loc == dragon_loc). s_hit_q is registered s_hit.
- Dragon hit event = s_hit & ~s_hit_q; counted in PLAY and HURT. Decrements segments. If segments reaches 0 → WIN.
- Player hit event = p_hit in PLAY only; ignored in HURT. Decrements health. If health reaches 0 → LOSE, else → HURT with hurt counter = HURT_FRAMES-1.
- Same-frame dragon and player hit: the dragon decrement applies first. If the dragon dies → WIN and the player hit is discarded. Otherwise both apply.
- HURT: invuln=1; hurt counter decrements each frame; at 0 → PLAY.
- WIN/LOSE: ticks 0, counts frozen, entity_rst=0. On start_rise → TITLE.
- Counters saturate at 0 and never wrap below.

## Timing
- All outputs registered; any event updates outputs on the next rising edge.
- Reset values: game_state=TITLE, entity_rst=1, player_tick=0, dragon_tick=0, player_health=MAX_HEALTH, dragon_segments=DRAGON_LEN, invuln=0, start_q=0, s_hit_q=0, counters 0.
- rst mid-game returns to TITLE in one frame, regardless of state.
- Ticks: first player_tick occurs PLAY_DIV frames after entering PLAY (frame PLAYER_TICK_DIV after the transition edge). Tick counters do not reset on PLAY↔HURT.
- HURT lasts exactly HURT_FRAMES frames.
- start held high gives only one transition.

## Configuration
- DRAGON_SPEEDUP_EN defined: each dragon hit event lowers the effective dragon divisor by 1, floor 2. The divisor reloads to DRAGON_TICK_DIV on TITLE→PLAY. If the counter is already ≥ the new divisor−1, it wraps to 0.
- DRAGON_SPEEDUP_EN undefined: divisor fixed at DRAGON_TICK_DIV.

## Structure
- Package game_pkg:
  - state localparams (TITLE…LOSE)
  - location field helpers (X=[7:4], Y=[3:0])
  - widths: health 2, segments 4, location 8
- Sub-module tick_divider: parameterised counter with runtime divisor input, enable and clear. Instantiated twice (player, dragon).
- Collision compare, health/segment logic and FSM live in game_sequencer.

## Test plan
- rst, then start pulse → TITLE with entity_rst=1, then PLAY next frame. With DIV=4: player_tick on frames 4, 8, 12 after the transition.
- PLAY, player_loc=dragon_loc=0x55 for 1 frame → health 3→2, HURT for 30 frames with invuln=1. Collision held through HURT gives no further loss; back to PLAY on frame 31.
- Health 1 and player hit → LOSE, ticks stop. start_rise → TITLE. Next start_rise → PLAY with health=3, segments=6.
- sword_active=1, sword_loc=dragon_loc held 10 frames → segments decrement once. Six separate hits → WIN.
- Segments 1, health 1, sword hit and player hit in the same frame → WIN, health remains 1.
- With DRAGON_SPEEDUP_EN and DRAGON_TICK_DIV=4: after 3 hits, dragon_tick period is 2 frames and does not go below 2. Without the macro the period stays 4.

Source files
------------

// File: rtl/game_sequencer_pkg.sv
// Shared types, widths and tile-location helpers for the game sequencer.
package game_pkg;

  localparam int LOC_W    = 8;
  localparam int HEALTH_W = 2;
  localparam int SEG_W    = 4;

  typedef enum logic [2:0] {
    ST_TITLE = 3'd0,
    ST_PLAY  = 3'd1,
    ST_HURT  = 3'd2,
    ST_WIN   = 3'd3,
    ST_LOSE  = 3'd4
  } state_e;

  function automatic logic [3:0] loc_x(input logic [LOC_W-1:0] loc);
    return loc[7:4];
  endfunction

  function automatic logic [3:0] loc_y(input logic [LOC_W-1:0] loc);
    return loc[3:0];
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Controller/entity-facing signal bundle of the game sequencer.
// All signals are levels sampled or updated once per frame_clk rising edge; there is no valid/ready handshake.
interface game_sequencer_if;
  import game_pkg::*;

  logic                start;
  logic [LOC_W-1:0]    player_loc;
  logic [LOC_W-1:0]    dragon_loc;
  logic [LOC_W-1:0]    sword_loc;
  logic                sword_active;
  logic [2:0]          game_state;
  logic                entity_rst;
  logic                player_tick;
  logic                dragon_tick;
  logic [HEALTH_W-1:0] player_health;
  logic [SEG_W-1:0]    dragon_segments;
  logic                invuln;

  modport master (
    output start, player_loc, dragon_loc, sword_loc, sword_active,
    input  game_state, entity_rst, player_tick, dragon_tick,
           player_health, dragon_segments, invuln
  );

  modport slave (
    input  start, player_loc, dragon_loc, sword_loc, sword_active,
    output game_state, entity_rst, player_tick, dragon_tick,
           player_health, dragon_segments, invuln
  );
endinterface

// File: rtl/game_sequencer_tick_divider.sv
// Frame divider: counts 0..div-1 while enabled and flags the frame at div-1.
// A counter already past a freshly lowered divisor wraps to 0 without a tick.
module tick_divider #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] div_i,
  output logic         tick_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q >= div_i - W'(1)) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = en_i & (cnt_q == div_i - W'(1));

endmodule

// File: rtl/game_sequencer.sv
// Per-frame game controller: state machine, move ticks, collisions, health and dragon segments.
// Optional DRAGON_SPEEDUP_EN: each dragon hit shortens the dragon tick period by one frame (floor 2).
module game_sequencer
  import game_pkg::*;
#(
  parameter int PLAYER_TICK_DIV = 4,
  parameter int DRAGON_TICK_DIV = 8,
  parameter int HURT_FRAMES     = 30,
  parameter int MAX_HEALTH      = 3,
  parameter int DRAGON_LEN      = 6
) (
  input  logic            frame_clk,
  input  logic            rst,
  game_sequencer_if.slave bus
);

  localparam int MAX_DIV = (PLAYER_TICK_DIV > DRAGON_TICK_DIV) ? PLAYER_TICK_DIV : DRAGON_TICK_DIV;
  localparam int DIV_W   = $clog2(MAX_DIV + 1);
  localparam int HURT_W  = $clog2(HURT_FRAMES + 1);

  state_e              state_q, state_d;
  logic                start_q, s_hit_q;
  logic [HEALTH_W-1:0] health_q, health_d;
  logic [SEG_W-1:0]    segs_q, segs_d;
  logic [HURT_W-1:0]   hurt_q, hurt_d;
  logic [DIV_W-1:0]    ddiv_q, ddiv_d;
  logic                clr_ticks, active, start_rise, p_hit, s_hit, d_event;

  assign start_rise = bus.start & ~start_q;
  assign p_hit   = (loc_x(bus.player_loc) == loc_x(bus.dragon_loc)) &&
                   (loc_y(bus.player_loc) == loc_y(bus.dragon_loc));
  assign s_hit   = bus.sword_active &&
                   (loc_x(bus.sword_loc) == loc_x(bus.dragon_loc)) &&
                   (loc_y(bus.sword_loc) == loc_y(bus.dragon_loc));
  assign d_event = s_hit & ~s_hit_q;
  assign active  = (state_q == ST_PLAY) || (state_q == ST_HURT);

  always_comb begin
    state_d   = state_q;
    health_d  = health_q;
    segs_d    = segs_q;
    hurt_d    = hurt_q;
    clr_ticks = 1'b0;
    case (state_q)
      ST_TITLE: begin
        if (start_rise) begin
          state_d   = ST_PLAY;
          health_d  = HEALTH_W'(MAX_HEALTH);
          segs_d    = SEG_W'(DRAGON_LEN);
          clr_ticks = 1'b1;
        end
      end
      ST_PLAY, ST_HURT: begin
        if (state_q == ST_HURT) begin
          if (hurt_q == '0) state_d = ST_PLAY;
          else              hurt_d  = hurt_q - HURT_W'(1);
        end
        // Dragon damage resolves first; a killing blow discards a same-frame player hit.
        if (d_event && segs_q != '0) segs_d = segs_q - SEG_W'(1);
        if (d_event && segs_d == '0) begin
          state_d = ST_WIN;
        end else if (state_q == ST_PLAY && p_hit) begin
          health_d = (health_q == '0) ? '0 : health_q - HEALTH_W'(1);
          if (health_d == '0) begin
            state_d = ST_LOSE;
          end else begin
            state_d = ST_HURT;
            hurt_d  = HURT_W'(HURT_FRAMES - 1);
          end
        end
      end
      ST_WIN, ST_LOSE: begin
        if (start_rise) state_d = ST_TITLE;
      end
      default: state_d = ST_TITLE;
    endcase
  end

`ifdef DRAGON_SPEEDUP_EN
  always_comb begin
    ddiv_d = ddiv_q;
    if (clr_ticks) begin
      ddiv_d = DIV_W'(DRAGON_TICK_DIV);
    end else if (active && d_event && ddiv_q > DIV_W'(2)) begin
      ddiv_d = ddiv_q - DIV_W'(1);
    end
  end
`else
  assign ddiv_d = DIV_W'(DRAGON_TICK_DIV);
`endif

  always_ff @(posedge frame_clk) begin
    if (rst) begin
      state_q  <= ST_TITLE;
      start_q  <= 1'b0;
      s_hit_q  <= 1'b0;
      health_q <= HEALTH_W'(MAX_HEALTH);
      segs_q   <= SEG_W'(DRAGON_LEN);
      hurt_q   <= '0;
      ddiv_q   <= DIV_W'(DRAGON_TICK_DIV);
    end else begin
      state_q  <= state_d;
      start_q  <= bus.start;
      s_hit_q  <= s_hit;
      health_q <= health_d;
      segs_q   <= segs_d;
      hurt_q   <= hurt_d;
      ddiv_q   <= ddiv_d;
    end
  end

  tick_divider #(.W(DIV_W)) u_player_div (
    .clk_i  (frame_clk),
    .rst_i  (rst),
    .en_i   (active),
    .clr_i  (clr_ticks),
    .div_i  (DIV_W'(PLAYER_TICK_DIV)),
    .tick_o (bus.player_tick)
  );

  tick_divider #(.W(DIV_W)) u_dragon_div (
    .clk_i  (frame_clk),
    .rst_i  (rst),
    .en_i   (active),
    .clr_i  (clr_ticks),
    .div_i  (ddiv_q),
    .tick_o (bus.dragon_tick)
  );

  assign bus.game_state      = state_q;
  assign bus.entity_rst      = (state_q == ST_TITLE);
  assign bus.invuln          = (state_q == ST_HURT);
  assign bus.player_health   = health_q;
  assign bus.dragon_segments = segs_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed and randomized frame-by-frame checks of game_sequencer against a behavioural model.
module tb_game_sequencer;

  localparam int P_DIV = 4;
  localparam int D_DIV = 4;
  localparam int HF    = 30;
  localparam int MH    = 3;
  localparam int DL    = 6;
  localparam int S_TITLE = 0, S_PLAY = 1, S_HURT = 2, S_WIN = 3, S_LOSE = 4;
`ifdef DRAGON_SPEEDUP_EN
  localparam int EXP_FAST_PERIOD = 2;
`else
  localparam int EXP_FAST_PERIOD = D_DIV;
`endif

  // clock / reset
  logic frame_clk = 1'b0;
  logic rst = 1'b1;
  always #5 frame_clk = ~frame_clk;

  game_sequencer_if bus ();

  game_sequencer #(
    .PLAYER_TICK_DIV (P_DIV),
    .DRAGON_TICK_DIV (D_DIV),
    .HURT_FRAMES     (HF),
    .MAX_HEALTH      (MH),
    .DRAGON_LEN      (DL)
  ) dut (
    .frame_clk (frame_clk),
    .rst       (rst),
    .bus       (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  // behavioural model: game rules in plain integers
  int m_state, m_health, m_segs, m_hurt, m_pframes, m_dpos, m_ddiv;
  bit m_start_q, m_shit_q;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit rise, shit, dev, phit, act;
    int nxt;
    if (rst) begin
      m_state = S_TITLE; m_health = MH; m_segs = DL; m_hurt = 0;
      m_pframes = 0; m_dpos = 1; m_ddiv = D_DIV; m_start_q = 0; m_shit_q = 0;
    end else begin
      rise = bus.start && !m_start_q;
      shit = bus.sword_active && (bus.sword_loc == bus.dragon_loc);
      dev  = shit && !m_shit_q;
      phit = (bus.player_loc == bus.dragon_loc);
      act  = (m_state == S_PLAY) || (m_state == S_HURT);
      nxt  = m_state;
      if (m_state == S_TITLE) begin
        if (rise) begin
          nxt = S_PLAY; m_health = MH; m_segs = DL;
          m_pframes = 1; m_dpos = 1; m_ddiv = D_DIV;
        end
      end else if (act) begin
        m_pframes++;
        if (m_dpos >= m_ddiv) m_dpos = 1; else m_dpos++;
`ifdef DRAGON_SPEEDUP_EN
        if (dev && m_ddiv > 2) m_ddiv--;
`endif
        if (m_state == S_HURT) begin
          if (m_hurt == 0) nxt = S_PLAY; else m_hurt--;
        end
        if (dev && m_segs > 0) m_segs--;
        if (dev && m_segs == 0) begin
          nxt = S_WIN;
        end else if (m_state == S_PLAY && phit) begin
          if (m_health > 0) m_health--;
          if (m_health == 0) nxt = S_LOSE;
          else begin nxt = S_HURT; m_hurt = HF - 1; end
        end
      end else if (m_state == S_WIN || m_state == S_LOSE) begin
        if (rise) nxt = S_TITLE;
      end else begin
        nxt = S_TITLE;
      end
      m_state = nxt; m_start_q = bus.start; m_shit_q = shit;
    end
  endtask

  task automatic compare_all();
    bit act;
    act = (m_state == S_PLAY) || (m_state == S_HURT);
    check("game_state", 16'(bus.game_state), 16'(m_state));
    check("entity_rst", 16'(bus.entity_rst), 16'(m_state == S_TITLE));
    check("invuln", 16'(bus.invuln), 16'(m_state == S_HURT));
    check("player_health", 16'(bus.player_health), 16'(m_health));
    check("dragon_segments", 16'(bus.dragon_segments), 16'(m_segs));
    check("player_tick", 16'(bus.player_tick), 16'(act && (m_pframes % P_DIV == 0)));
    check("dragon_tick", 16'(bus.dragon_tick), 16'(act && (m_dpos == m_ddiv)));
  endtask

  // driver tasks
  task automatic step();
    @(posedge frame_clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic wait_state(input int target, input int budget);
    int n;
    n = 0;
    while (int'(bus.game_state) != target && n < budget) begin
      step();
      n++;
    end
    check("wait_state", 16'(bus.game_state), 16'(target));
  endtask

  task automatic player_hit();
    bus.player_loc = bus.dragon_loc;
    step();
    bus.player_loc = 8'h11;
  endtask

  task automatic sword_hit();
    bus.sword_loc = bus.dragon_loc;
    bus.sword_active = 1'b1;
    step();
    bus.sword_active = 1'b0;
    step();
  endtask

  task automatic restart();
    bus.start = 1'b1; step();
    bus.start = 1'b0; step();
    bus.start = 1'b1; step();
    bus.start = 1'b0;
  endtask

  task automatic measure_dperiod(output int p);
    int n;
    n = 0;
    while (!bus.dragon_tick && n < 20) begin step(); n++; end
    p = 0;
    do begin step(); p++; end while (!bus.dragon_tick && p < 20);
  endtask

  initial begin
    logic [15:0] tick_mask;
    int hurt_n, per;

    bus.start = 1'b0; bus.player_loc = 8'h11; bus.dragon_loc = 8'h55;
    bus.sword_loc = 8'h22; bus.sword_active = 1'b0;

    // reset
    step(); step();
    rst = 1'b0;
    step();
    check("rst_state", 16'(bus.game_state), 16'(S_TITLE));
    check("rst_entity_rst", 16'(bus.entity_rst), 16'd1);
    check("rst_health", 16'(bus.player_health), 16'(MH));
    check("rst_segments", 16'(bus.dragon_segments), 16'(DL));

    // start held high: one transition, player ticks on frames 4, 8, 12
    bus.start = 1'b1;
    step();
    check("start_to_play", 16'(bus.game_state), 16'(S_PLAY));
    tick_mask = '0;
    tick_mask[1] = bus.player_tick;
    for (int f = 2; f <= 12; f++) begin
      step();
      tick_mask[f] = bus.player_tick;
    end
    check("ptick_frames", tick_mask, 16'h1110);
    bus.start = 1'b0;

    // player hit with collision held through HURT
    bus.player_loc = 8'h55;
    step();
    hurt_n = 0;
    while (bus.invuln && hurt_n < 100) begin
      hurt_n++;
      step();
    end
    check("hurt_len", 16'(hurt_n), 16'(HF));
    check("after_hurt_state", 16'(bus.game_state), 16'(S_PLAY));
    check("health_after_hurt", 16'(bus.player_health), 16'd2);
    bus.player_loc = 8'h11;

    // down to LOSE, then back through TITLE to a fresh game
    player_hit();
    wait_state(S_PLAY, 40);
    player_hit();
    check("lose_state", 16'(bus.game_state), 16'(S_LOSE));
    repeat (5) step();
    check("lose_ptick", 16'(bus.player_tick), 16'd0);
    bus.start = 1'b1; step();
    check("lose_to_title", 16'(bus.game_state), 16'(S_TITLE));
    bus.start = 1'b0; step();
    bus.start = 1'b1; step();
    bus.start = 1'b0;
    check("replay_health", 16'(bus.player_health), 16'(MH));
    check("replay_segments", 16'(bus.dragon_segments), 16'(DL));

    // sword held on the dragon counts once; six hits win
    bus.sword_loc = bus.dragon_loc;
    bus.sword_active = 1'b1;
    repeat (10) step();
    bus.sword_active = 1'b0;
    step();
    check("held_sword_segments", 16'(bus.dragon_segments), 16'(DL - 1));
    repeat (5) sword_hit();
    check("win_state", 16'(bus.game_state), 16'(S_WIN));

    // same-frame killing blow and player hit
    restart();
    player_hit(); wait_state(S_PLAY, 40);
    player_hit(); wait_state(S_PLAY, 40);
    check("health_one", 16'(bus.player_health), 16'd1);
    repeat (5) sword_hit();
    check("segments_one", 16'(bus.dragon_segments), 16'd1);
    bus.sword_loc = bus.dragon_loc;
    bus.sword_active = 1'b1;
    bus.player_loc = bus.dragon_loc;
    step();
    check("tie_state", 16'(bus.game_state), 16'(S_WIN));
    check("tie_health", 16'(bus.player_health), 16'd1);
    bus.sword_active = 1'b0;
    bus.player_loc = 8'h11;
    step();

    // dragon period after three and four hits
    restart();
    repeat (3) sword_hit();
    repeat (6) step();
    measure_dperiod(per);
    check("dperiod_3hits", 16'(per), 16'(EXP_FAST_PERIOD));
    sword_hit();
    repeat (6) step();
    measure_dperiod(per);
    check("dperiod_4hits", 16'(per), 16'(EXP_FAST_PERIOD));

    // mid-game reset
    rst = 1'b1;
    step();
    check("midgame_rst_state", 16'(bus.game_state), 16'(S_TITLE));
    check("midgame_rst_entity", 16'(bus.entity_rst), 16'd1);
    rst = 1'b0;

    // randomized play
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      bus.start = ($urandom_range(0, 24) == 0);
      bus.player_loc = ($urandom_range(0, 9) == 0) ? 8'h55 : 8'h11;
      bus.dragon_loc = ($urandom_range(0, 3) == 0) ? 8'h56 : 8'h55;
      bus.sword_loc = ($urandom_range(0, 1) == 0) ? 8'h55 : 8'(($urandom_range(0, 255)));
      bus.sword_active = 1'($urandom_range(0, 1));
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
